verdict_dispatch: RTL

Per-packet forward/drop controller between the header parser and the output stream. Pops one 1-bit verdict per packet from the parser's verdict FIFO. Then either forwards the matching buffered packet beat-for-beat onto the master AXI stream or discards it entirely. Keeps forwarded and dropped packet counts for the register block.

---
 rtl/verdict_dispatch_pkg.sv | 25 ++
 rtl/verdict_dispatch_sat_counter.sv | 32 +++
 rtl/verdict_dispatch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/verdict_dispatch_pkg.sv
// Shared definitions for verdict_dispatch: FSM state encoding, mode codes,
// and the helper that resolves a popped verdict against the mode override.
// Latency/backpressure: not applicable (types and constants only).
package verdict_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FORWARD = 2'b01,
    ST_DROP    = 2'b10
  } state_t;

  localparam logic [1:0] MODE_VERDICT = 2'b00;
  localparam logic [1:0] MODE_FWD     = 2'b01;
  localparam logic [1:0] MODE_DROP    = 2'b10;

  // 1 = forward, 0 = drop. Mode 2'b11 behaves like MODE_VERDICT.
  function automatic logic eff_verdict(input logic [1:0] mode, input logic dout);
    case (mode)
      MODE_FWD:  return 1'b1;
      MODE_DROP: return 1'b0;
      default:   return dout;
    endcase
  endfunction

endpackage

// File: rtl/verdict_dispatch_sat_counter.sv
// Saturating up-counter: increments by one per inc pulse and sticks at all-ones.
// Latency: count updates on the clock edge after inc. No backpressure.
// Ports: clk, rst_n (async active-low), inc, count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/verdict_dispatch.sv
// Per-packet forward/drop dispatcher: pops one verdict per packet, then passes
// the buffered packet to m_axis (0-cycle combinational path) or discards it.
// Backpressure: in FORWARD s_axis_tready mirrors m_axis_tready; DROP always ready.
// Ports: axi_aclk/axi_aresetn, verdict FIFO (empty/dout/rd_en), mode,
//   s_axis_* in, m_axis_* out, pkt_fwd_count/pkt_drop_count statistics.
// Build option: define VERDICT_DISPATCH_STATS_EN to build the packet counters;
//   otherwise both count outputs are tied to zero.
module verdict_dispatch #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic                              verdict_empty,
  input  logic                              verdict_dout,
  output logic                              verdict_rd_en,
  input  logic [1:0]                        mode,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [C_CNT_WIDTH-1:0]            pkt_fwd_count,
  output logic [C_CNT_WIDTH-1:0]            pkt_drop_count
);

  import verdict_dispatch_pkg::*;

  state_t state_q, state_d;
  logic   rd_en;
  logic   s_rdy;
  logic   m_vld;
  logic   eop;

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    s_rdy   = 1'b0;
    m_vld   = 1'b0;
    eop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!verdict_empty) begin
          rd_en   = 1'b1;
          state_d = eff_verdict(mode, verdict_dout) ? ST_FORWARD : ST_DROP;
        end
      end
      ST_FORWARD: begin
        s_rdy = m_axis_tready;
        m_vld = s_axis_tvalid;
      end
      ST_DROP: begin
        s_rdy = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // s_rdy is low in IDLE, so an end of packet can only occur while a
    // packet is active. Chain straight into the next packet when a verdict
    // is already waiting, so back-to-back packets see no bubble.
    eop = s_axis_tvalid & s_rdy & s_axis_tlast;
    if (eop) begin
      if (!verdict_empty) begin
        rd_en   = 1'b1;
        state_d = eff_verdict(mode, verdict_dout) ? ST_FORWARD : ST_DROP;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The pop strobe is held off while reset is asserted even if the FIFO
  // still shows data, so no verdict is lost across a reset.
  assign verdict_rd_en = rd_en & axi_aresetn;
  assign s_axis_tready = s_rdy;
  assign m_axis_tvalid = m_vld;

  // Data path is unconditional pass-through; it is only meaningful when
  // m_axis_tvalid is high (FORWARD).
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;

`ifdef VERDICT_DISPATCH_STATS_EN
  logic fwd_inc, drop_inc;

  assign fwd_inc  = eop & (state_q == ST_FORWARD);
  assign drop_inc = eop & (state_q == ST_DROP);

  sat_counter #(.WIDTH(C_CNT_WIDTH)) u_fwd_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .inc   (fwd_inc),
    .count (pkt_fwd_count)
  );

  sat_counter #(.WIDTH(C_CNT_WIDTH)) u_drop_cnt (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .inc   (drop_inc),
    .count (pkt_drop_count)
  );
`else
  assign pkt_fwd_count  = '0;
  assign pkt_drop_count = '0;
`endif

endmodule
